// File: rtl/sll_iter.sv
// Iterative 16-bit shift-left / rotate-left unit: a 4-stage barrel shift
// done one power-of-two stage per clock (8, 4, 2, 1) behind a small FSM.
module sll_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] in,
    input  logic [3:0]  cnt,
    input  logic        mode,
    output logic [15:0] out,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_work;
    logic [15:0] w_work_next;
    logic [15:0] r_out;
    logic [3:0]  r_cnt;
    logic        r_mode;
    logic [1:0]  r_stage;

    // Shift v left by 2**stage; in rotate mode the bits leaving the MSB end re-enter at the LSB end.
    function automatic logic [15:0] f_stage_shift(input logic [15:0] v,
                                                  input logic [1:0]  stage,
                                                  input logic        rot);
        logic [15:0] res;
        case (stage)
            2'd3:    res = rot ? {v[7:0],  v[15:8]}  : {v[7:0],  8'h00};
            2'd2:    res = rot ? {v[11:0], v[15:12]} : {v[11:0], 4'h0};
            2'd1:    res = rot ? {v[13:0], v[15:14]} : {v[13:0], 2'b00};
            2'd0:    res = rot ? {v[14:0], v[15]}    : {v[14:0], 1'b0};
            default: res = v;
        endcase
        return res;
    endfunction

    // Working value after the current stage, gated by the latched count bit.
    always_comb begin
        w_work_next = r_work;
        if (r_cnt[r_stage]) begin
            w_work_next = f_stage_shift(r_work, r_stage, r_mode);
        end else begin
            w_work_next = r_work;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_SHIFT;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (r_stage == 2'd0) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_SHIFT;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // State, operand capture, per-stage datapath update and result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_work  <= 16'h0000;
            r_out   <= 16'h0000;
            r_cnt   <= 4'h0;
            r_mode  <= 1'b0;
            r_stage <= 2'd0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_work  <= in;
                        r_cnt   <= cnt;
                        r_mode  <= mode;
                        r_stage <= 2'd3;
                    end
                end
                S_SHIFT: begin
                    r_work  <= w_work_next;
                    r_stage <= r_stage - 2'd1;
                    // The last stage's result goes straight to the output as DONE is entered.
                    if (r_stage == 2'd0) begin
                        r_out <= w_work_next;
                    end
                end
                S_DONE:  r_stage <= 2'd0;
                default: r_stage <= 2'd0;
            endcase
        end
    end

    assign out  = r_out;
    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_sll_iter.sv
// Self-checking bench for sll_iter: directed vector table, hand-written
// corner sequences and randomized operations against a bit-serial model.
module tb_sll_iter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] in;
    logic [3:0]  cnt;
    logic        mode;
    logic [15:0] out;
    logic        busy;
    logic        done;

    int checks;
    int errors;
    int n_done;
    int n_ops;

    sll_iter dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in    (in),
        .cnt   (cnt),
        .mode  (mode),
        .out   (out),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) n_done++;
    end

    typedef struct {
        logic [15:0] v_in;
        logic [3:0]  v_cnt;
        logic        v_mode;
        logic [15:0] v_exp;
        string       v_name;
    } vec_t;

    // Reference: apply cnt single-bit moves, one at a time.
    function automatic logic [15:0] ref_model(input logic [15:0] v, input logic [3:0] c, input logic m);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < int'(c); i++) begin
            r = m ? {r[14:0], r[15]} : {r[14:0], 1'b0};
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One full operation with cycle-accurate busy/done/out checks; inputs scrambled after acceptance.
    task automatic run_op(input logic [15:0] v_in, input logic [3:0] v_cnt, input logic v_mode,
                          input logic [15:0] exp, input string name);
        @(negedge clk);
        start = 1'b1; in = v_in; cnt = v_cnt; mode = v_mode;
        @(negedge clk);
        start = 1'b0; in = 16'($urandom); cnt = 4'($urandom); mode = 1'($urandom);
        chk({name, ".busy0"}, {31'd0, busy}, 32'd1);
        chk({name, ".done0"}, {31'd0, done}, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk({name, ".busy"}, {31'd0, busy}, 32'd1);
            chk({name, ".done"}, {31'd0, done}, (i == 4) ? 32'd1 : 32'd0);
        end
        chk({name, ".out"}, {16'd0, out}, {16'd0, exp});
        @(negedge clk);
        chk({name, ".idle_busy"}, {31'd0, busy}, 32'd0);
        chk({name, ".idle_done"}, {31'd0, done}, 32'd0);
        chk({name, ".hold_out"}, {16'd0, out}, {16'd0, exp});
        n_ops++;
    endtask

    vec_t vecs[6];

    initial begin
        checks = 0; errors = 0; n_done = 0; n_ops = 0;
        rst = 1'b1; start = 1'b0; in = 16'h0000; cnt = 4'h0; mode = 1'b0;

        vecs[0] = '{16'h00FF, 4'd8,  1'b0, 16'hFF00, "shl8"};
        vecs[1] = '{16'h8001, 4'd1,  1'b1, 16'h0003, "rol1"};
        vecs[2] = '{16'h1234, 4'd4,  1'b1, 16'h2341, "rol4"};
        vecs[3] = '{16'hFFFF, 4'd15, 1'b0, 16'h8000, "shl15"};
        vecs[4] = '{16'hABCD, 4'd0,  1'b0, 16'hABCD, "cnt0"};
        vecs[5] = '{16'h8421, 4'd15, 1'b1, 16'hC210, "rol15"};

        #1;
        chk("rst.out",  {16'd0, out}, 32'd0);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.done", {31'd0, done}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].v_in, vecs[i].v_cnt, vecs[i].v_mode, vecs[i].v_exp, vecs[i].v_name);
        end

        // start held high across the whole operation, with changing operands.
        @(negedge clk);
        start = 1'b1; in = 16'h5555; cnt = 4'd1; mode = 1'b0;
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            in = 16'($urandom); cnt = 4'($urandom); mode = 1'($urandom);
            chk("hold.done", {31'd0, done}, (i == 4) ? 32'd1 : 32'd0);
        end
        chk("hold.out", {16'd0, out}, 32'h0000AAAA);
        @(negedge clk);
        start = 1'b0;
        chk("hold.busy_after", {31'd0, busy}, 32'd0);
        n_ops++;
        repeat (3) begin
            @(negedge clk);
            chk("hold.no_extra_done", {31'd0, done}, 32'd0);
            chk("hold.out_kept", {16'd0, out}, 32'h0000AAAA);
        end

        // Reset pulsed mid-operation, between edges, while stage 2 is pending.
        @(negedge clk);
        start = 1'b1; in = 16'h0F0F; cnt = 4'd4; mode = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort.out",  {16'd0, out}, 32'd0);
        chk("abort.busy", {31'd0, busy}, 32'd0);
        chk("abort.done", {31'd0, done}, 32'd0);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("abort.no_done", {31'd0, done}, 32'd0);
            chk("abort.no_busy", {31'd0, busy}, 32'd0);
        end
        run_op(16'h0F0F, 4'd4, 1'b0, 16'hF0F0, "after_abort");

        for (int n = 0; n < 1000; n++) begin
            logic [15:0] r_in;
            logic [3:0]  r_c;
            logic        r_m;
            r_in = 16'($urandom);
            r_c  = 4'($urandom);
            r_m  = 1'($urandom);
            run_op(r_in, r_c, r_m, ref_model(r_in, r_c, r_m), "rand");
        end

        chk("done_count", n_done, n_ops);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
